uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares the single UART transmitter between N byte requesters (switch/button push, keyboard ASCII, ...).
//  Buffers each requester's bytes and picks one requester by round-robin.
//  Issues a one-cycle start pulse with the data to the UART and sequences it through its busy handshake.
//  Sits between the input sources (buttons, PS/2 decode) and the uart instance in the top level.
// PARAMETERS
//  N_REQ       2     number of requesters (1..8); index 0 wins ties only when the RR pointer is at 0
//  DATA_W      8     byte width
//  FIFO_DEPTH  4     entries per requester when TX_FIFO_EN is defined (power of 2, >=2)
//  BUSY_WAIT   16    cycles to wait for tx_busy to rise after a start pulse before abandoning the wait
// PORTS
//  clk         in   1               system clock
//  rst         in   1               asynchronous, active-high reset
//  req_valid   in   N_REQ           per-requester byte offer; sampled on clk
//  req_data    in   N_REQ*DATA_W    requester i data at [i*DATA_W +: DATA_W]
//  req_ready   out  N_REQ           slot available; a byte is accepted when valid&ready on a clk edge
//  tx_data     out  DATA_W          byte to the UART; held stable from the start pulse until done
//  tx_start    out  1               one-cycle start pulse to the UART
//  tx_busy     in   1               UART busy flag
//  grant_id    out  $clog2(N_REQ)   requester whose byte is in flight (max(1,...) bits)
//  tx_active   out  1               high from the start pulse until the byte is complete
//  overflow    out  N_REQ           sticky per-requester flag: valid asserted while not ready
// BEHAVIOUR
//  Reset values (async, effective immediately):
//   tx_start=0, tx_data=0, grant_id=0, tx_active=0, overflow=0.
//   All buffers are empty, so req_ready = all ones. RR pointer=0. State=IDLE.
//  Accept: req_valid[i] & req_ready[i] at a clk edge writes the byte. Overflow:
//   - valid & !ready sets overflow[i]; only rst clears it.
//   - The byte is dropped, never overwrites.
//  FSM states:
//   - IDLE: if any buffer is non-empty, select the first non-empty requester scanning from the RR pointer upward (wrapping).
//     Pop its head into tx_data, set grant_id, and go to LAUNCH.
//   - LAUNCH: tx_start=1 for exactly this cycle, tx_active=1. Reset the wait counter to 0 and go to WAIT_BUSY.
//     The RR pointer becomes grant_id+1 (mod N_REQ).
//   - WAIT_BUSY: tx_busy=1 -> WAIT_DONE. If the counter reaches BUSY_WAIT-1 with tx_busy still 0 -> IDLE.
//     On that timeout the byte is considered sent, not retried.
//   - WAIT_DONE: on tx_busy=0 -> IDLE and tx_active=0 the same cycle.
//  Latency: a byte offered to an empty, idle arbiter is accepted at edge 0. It enters IDLE-select at edge 1 and tx_start is high in cycle 2.
//  Back-to-back bytes: at least 1 IDLE cycle between the completion of one byte and the next tx_start.
//  Simultaneous push and pop on the same buffer:
//   - Both happen.
//   - When the buffer is full, req_ready is already 0 that cycle, so the push is refused.
//   - The pop frees the slot only for the next cycle.
//  tx_busy high while in IDLE is ignored; the selection still waits for IDLE only.
//  Reset mid-transfer: the in-flight byte and all buffered bytes are lost. tx_start drops immediately.
// CONFIGURATION
//  TX_FIFO_EN defined:
//   - Each requester gets a FIFO_DEPTH-entry FIFO.
//   - req_ready[i] = !full[i]; a requester can queue FIFO_DEPTH bytes while the UART is busy.
//  TX_FIFO_EN undefined:
//   - Each requester gets a one-entry holding register with a valid bit.
//   - req_ready[i] = !held[i]; the FIFO_DEPTH parameter is ignored.
//  The FSM, RR policy and ports are identical in both builds.
// STRUCTURE
//  Package uart_arb_pkg: FSM state encoding (IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE); default DATA_W=8.
//  Package uart_arb_pkg: function rr_pick(mask, ptr) -> index.
//  One sub-module: uart_arb_fifo (DATA_W, DEPTH).
//   - Ports: push/pop/data, full/empty.
//   - Instantiated N_REQ times; degenerates to the holding register when DEPTH=1 in the non-FIFO build.
//  The arbiter top holds the FSM, the RR pointer, the wait counter and the overflow flags.
// TESTING
//  1 Single byte: push req0=0x41, UART model raises busy 1 cycle after start for 10 cycles.
//    -> tx_start high in cycle 2, tx_data=0x41, grant_id=0, tx_active falls with busy.
//  2 Contention: push req0=0x31 and req1=0x32 on the same edge, pointer=0.
//    -> 0x31 sent then 0x32; next simultaneous pair is sent in the same order 0,1 (pointer wrapped).
//  3 Fairness: req0 pushes continuously and req1 pushes one byte 0x55.
//    -> 0x55 is sent at most one byte after the current in-flight one.
//  4 Full/overflow (TX_FIFO_EN, DEPTH=4): hold busy high and push 6 bytes 0x01..0x06 on req1.
//    -> ready drops after 4 bytes and overflow[1]=1; the UART sees exactly 0x01..0x04 in order.
//  5 Busy timeout: the UART model never asserts busy after a start.
//    -> the FSM returns to IDLE after BUSY_WAIT=16 cycles and the next queued byte is launched.
//  6 Reset mid-transfer: assert rst in WAIT_DONE with 2 bytes queued.
//    -> outputs reset asynchronously, req_ready=all ones, overflow=0, and no tx_start follows the release.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter: FSM encoding and
// the round-robin selector used to pick the next requester.
package uart_arb_pkg;

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} arb_state_t;

    localparam int DEF_DATA_W = 8;
    localparam int MAX_REQ    = 8;

    // First set bit of mask at or above ptr, wrapping modulo n.
    function automatic logic [2:0] rr_pick(input logic [7:0] mask, input logic [2:0] ptr,
                                           input int n);
        logic found;
        int   j;
        rr_pick = ptr;
        found   = 1'b0;
        for (int i = 0; i < MAX_REQ; i++) begin
            j = (int'(ptr) + i) % n;
            if (!found && i < n && mask[3'(j)]) begin
                rr_pick = 3'(j);
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/uart_arb_fifo.sv
// Per-requester byte buffer: a one-entry holding register when DEPTH=1,
// otherwise a power-of-two circular FIFO. Push when full / pop when empty are ignored.
module uart_arb_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty
);

    generate
        if (DEPTH == 1) begin : g_hold
            logic [DATA_W-1:0] hold;
            logic              held;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    held <= 1'b0;
                    hold <= '0;
                end else begin
                    // A full register refuses the push even while it is being popped.
                    held <= held ? !pop : push;
                    if (push && !held) hold <= wdata;
                end
            end

            assign rdata = hold;
            assign full  = held;
            assign empty = !held;
        end else begin : g_fifo
            localparam int AW = $clog2(DEPTH);
            localparam int CW = $clog2(DEPTH + 1);

            logic [DATA_W-1:0] mem [DEPTH];
            logic [AW-1:0]     wr_ptr, rd_ptr;
            logic [CW-1:0]     count;
            logic              do_push, do_pop;

            assign full    = (count == CW'(DEPTH));
            assign empty   = (count == '0);
            assign do_push = push && !full;
            assign do_pop  = pop && !empty;
            assign rdata   = mem[rd_ptr];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                    count  <= '0;
                end else begin
                    if (do_push) wr_ptr <= wr_ptr + AW'(1);
                    if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
                    count <= count + CW'(do_push) - CW'(do_pop);
                end
            end

            always_ff @(posedge clk) begin
                if (do_push) mem[wr_ptr] <= wdata;
            end
        end
    endgenerate

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ byte sources.
// Define TX_FIFO_EN for FIFO_DEPTH-entry queues; otherwise each source has one holding register.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ      = 2,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIFO_DEPTH = 4,
    parameter int BUSY_WAIT  = 16
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [N_REQ-1:0]                              req_valid,
    input  logic [N_REQ*DATA_W-1:0]                       req_data,
    output logic [N_REQ-1:0]                              req_ready,
    output logic [DATA_W-1:0]                             tx_data,
    output logic                                          tx_start,
    input  logic                                          tx_busy,
    output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0]  grant_id,
    output logic                                          tx_active,
    output logic [N_REQ-1:0]                              overflow
);

    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT) : 1;
`ifdef TX_FIFO_EN
    localparam int DEPTH = FIFO_DEPTH;
`else
    localparam int DEPTH = 1 + 0 * FIFO_DEPTH;
`endif

    logic [N_REQ-1:0]             full, empty, push, pop;
    logic [N_REQ-1:0][DATA_W-1:0] rdata;
    arb_state_t                   state, state_nxt;
    logic [GW-1:0]                rr_ptr, pick;
    logic [CW-1:0]                wait_cnt;
    logic                         any_pending;

    assign req_ready   = ~full;
    assign push        = req_valid & ~full;
    assign any_pending = !(&empty);
    assign pick        = GW'(rr_pick(8'(~empty), 3'(rr_ptr), N_REQ));

    generate
        for (genvar g = 0; g < N_REQ; g++) begin : g_req
            uart_arb_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_buf (
                .clk   (clk),
                .rst   (rst),
                .push  (push[g]),
                .pop   (pop[g]),
                .wdata (req_data[g*DATA_W +: DATA_W]),
                .rdata (rdata[g]),
                .full  (full[g]),
                .empty (empty[g])
            );
        end
    endgenerate

    always_comb begin
        state_nxt = state;
        pop       = '0;
        tx_start  = 1'b0;
        tx_active = 1'b0;
        case (state)
            IDLE: begin
                if (any_pending) begin
                    pop[pick] = 1'b1;
                    state_nxt = LAUNCH;
                end
            end
            LAUNCH: begin
                tx_start  = 1'b1;
                tx_active = 1'b1;
                state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                tx_active = 1'b1;
                // A UART that never acknowledges is treated as having sent the byte.
                if (tx_busy)                             state_nxt = WAIT_DONE;
                else if (wait_cnt == CW'(BUSY_WAIT - 1)) state_nxt = IDLE;
            end
            WAIT_DONE: begin
                tx_active = tx_busy;
                if (!tx_busy) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            wait_cnt <= '0;
            tx_data  <= '0;
            grant_id <= '0;
            overflow <= '0;
        end else begin
            state    <= state_nxt;
            overflow <= overflow | (req_valid & full);
            case (state)
                IDLE: begin
                    if (any_pending) begin
                        tx_data  <= rdata[pick];
                        grant_id <= pick;
                    end
                end
                LAUNCH: begin
                    wait_cnt <= '0;
                    rr_ptr   <= (grant_id == GW'(N_REQ - 1)) ? '0 : grant_id + GW'(1);
                end
                WAIT_BUSY: wait_cnt <= wait_cnt + CW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter with a behavioural UART busy model.
module tb_uart_tx_arbiter;

`ifdef TX_FIFO_EN
    localparam int DEPTH_EXP = 4;
`else
    localparam int DEPTH_EXP = 1;
`endif

    logic        clk, rst, tx_busy, tx_start, tx_active;
    logic [1:0]  req_valid, req_ready, overflow;
    logic [15:0] req_data;
    logic [7:0]  tx_data;
    logic [0:0]  grant_id;

    int          checks = 0, errors = 0;
    int          uart_mode = 0;   // 0: busy 10 cycles after start, 1: never busy, 2: busy held high
    int          busy_left = 0;
    bit          start_seen = 0;
    logic [7:0]  sent[$];
    logic [0:0]  gids[$];

    uart_tx_arbiter #(.N_REQ(2), .DATA_W(8), .FIFO_DEPTH(4), .BUSY_WAIT(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .grant_id(grant_id), .tx_active(tx_active), .overflow(overflow));

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // UART model: logs every start pulse and answers with busy one cycle later.
    initial begin
        tx_busy = 0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                busy_left = 0; start_seen = 0;
                if (uart_mode != 2) tx_busy = 0;
            end else begin
                if (uart_mode == 0) begin
                    if (start_seen) begin busy_left = 10; start_seen = 0; end
                    if (busy_left > 0) begin tx_busy = 1; busy_left--; end else tx_busy = 0;
                end else if (uart_mode == 1) tx_busy = 0;
                else tx_busy = 1;
                if (tx_start) begin
                    sent.push_back(tx_data); gids.push_back(grant_id);
                    if (uart_mode == 0) start_seen = 1;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        @(negedge clk);
        rst = 1; req_valid = 0;
        sent.delete(); gids.delete();
        repeat (2) @(negedge clk);
        rst = 0;
    endtask

    task automatic wait_sent(input int n, input int budget, output bit ok);
        ok = 0;
        for (int k = 0; k < budget; k++) begin
            if (sent.size() >= n) break;
            @(negedge clk);
        end
        if (sent.size() >= n) ok = 1;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL rst_tx_start got %b want 0", tx_start); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data got %h want 00", tx_data); end
        checks++; if (grant_id !== 1'b0) begin errors++; $display("FAIL rst_grant got %b want 0", grant_id); end
        checks++; if (tx_active !== 1'b0) begin errors++; $display("FAIL rst_active got %b want 0", tx_active); end
        checks++; if (overflow !== 2'b00) begin errors++; $display("FAIL rst_overflow got %b want 00", overflow); end
        checks++; if (req_ready !== 2'b11) begin errors++; $display("FAIL rst_ready got %b want 11", req_ready); end
        @(negedge clk); rst = 0;
    endtask

    task automatic test_single();
        bit seen = 0, act_busy = 0;
        uart_mode = 0; apply_reset();
        req_valid = 2'b01; req_data[7:0] = 8'h41;
        @(negedge clk); req_valid = 0;
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL single_c1_start got %b want 0", tx_start); end
        @(negedge clk);
        checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL single_c2_start got %b want 1", tx_start); end
        checks++; if (tx_data !== 8'h41) begin errors++; $display("FAIL single_data got %h want 41", tx_data); end
        checks++; if (grant_id !== 1'b0) begin errors++; $display("FAIL single_grant got %b want 0", grant_id); end
        checks++; if (tx_active !== 1'b1) begin errors++; $display("FAIL single_active got %b want 1", tx_active); end
        @(negedge clk);
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL single_c3_start got %b want 0", tx_start); end
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (tx_busy) begin seen = 1; act_busy = tx_active; end
            else if (seen) break;
        end
        checks++; if (!(seen && !tx_busy)) begin errors++; $display("FAIL single_busy_seq got seen=%b busy=%b want 1,0", seen, tx_busy); end
        checks++; if (act_busy !== 1'b1) begin errors++; $display("FAIL single_active_busy got %b want 1", act_busy); end
        checks++; if (tx_active !== 1'b0) begin errors++; $display("FAIL single_active_fall got %b want 0", tx_active); end
        checks++; if (sent.size() != 1) begin errors++; $display("FAIL single_count got %0d want 1", sent.size()); end
    endtask

    task automatic test_contention();
        bit ok;
        uart_mode = 0; apply_reset();
        req_valid = 2'b11; req_data = {8'h32, 8'h31};
        @(negedge clk); req_valid = 0;
        wait_sent(2, 80, ok);
        checks++; if (!ok) begin errors++; $display("FAIL cont_first_pair timeout got %0d bytes want 2", sent.size()); end
        repeat (2) @(negedge clk);
        req_valid = 2'b11; req_data = {8'h34, 8'h33};
        @(negedge clk); req_valid = 0;
        wait_sent(4, 80, ok);
        checks++; if (!ok) begin errors++; $display("FAIL cont_second_pair timeout got %0d bytes want 4", sent.size()); end
        if (ok) begin
            checks++; if ({sent[0], sent[1], sent[2], sent[3]} !== 32'h31323334) begin
                errors++; $display("FAIL cont_order got %h%h%h%h want 31323334", sent[0], sent[1], sent[2], sent[3]); end
            checks++; if ({gids[0], gids[1], gids[2], gids[3]} !== 4'b0101) begin
                errors++; $display("FAIL cont_grants got %b%b%b%b want 0101", gids[0], gids[1], gids[2], gids[3]); end
        end
    endtask

    task automatic test_fairness();
        bit ok, found = 0;
        uart_mode = 0; apply_reset();
        req_valid = 2'b01; req_data = 16'h00A0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (tx_start) begin found = 1; break; end
        end
        checks++; if (!found) begin errors++; $display("FAIL fair_first_start timeout got 0 want 1"); end
        req_valid = 2'b11; req_data = 16'h55A0;
        @(negedge clk); req_valid = 2'b01;
        wait_sent(3, 120, ok);
        req_valid = 0;
        checks++; if (!ok) begin errors++; $display("FAIL fair_sent timeout got %0d bytes want 3", sent.size()); end
        if (ok) begin
            checks++; if ({sent[0], sent[1], sent[2]} !== 24'hA055A0) begin
                errors++; $display("FAIL fair_order got %h%h%h want A055A0", sent[0], sent[1], sent[2]); end
            checks++; if (gids[1] !== 1'b1) begin errors++; $display("FAIL fair_grant got %b want 1", gids[1]); end
        end
        checks++; if (overflow !== 2'b01) begin errors++; $display("FAIL fair_overflow got %b want 01", overflow); end
    endtask

    task automatic test_full();
        bit ok;
        uart_mode = 0; apply_reset();
        uart_mode = 2;
        req_valid = 2'b01; req_data = 16'h00EE;
        @(negedge clk); req_valid = 0;
        repeat (4) @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            checks++; if (req_ready[1] !== (k < DEPTH_EXP)) begin
                errors++; $display("FAIL full_ready_%0d got %b want %b", k, req_ready[1], (k < DEPTH_EXP)); end
            req_valid = 2'b10; req_data = {8'(k + 1), 8'h00};
            @(negedge clk);
        end
        req_valid = 0;
        checks++; if (overflow !== 2'b10) begin errors++; $display("FAIL full_overflow got %b want 10", overflow); end
        uart_mode = 0;
        wait_sent(1 + DEPTH_EXP, 200, ok);
        repeat (30) @(negedge clk);
        checks++; if (sent.size() != 1 + DEPTH_EXP) begin
            errors++; $display("FAIL full_count got %0d want %0d", sent.size(), 1 + DEPTH_EXP); end
        if (sent.size() == 1 + DEPTH_EXP) begin
            checks++; if (sent[0] !== 8'hEE) begin errors++; $display("FAIL full_first got %h want EE", sent[0]); end
            for (int k = 0; k < DEPTH_EXP; k++) begin
                checks++; if (sent[1 + k] !== 8'(k + 1) || gids[1 + k] !== 1'b1) begin
                    errors++; $display("FAIL full_byte_%0d got %h/%b want %h/1", k, sent[1 + k], gids[1 + k], 8'(k + 1)); end
            end
        end
    endtask

    task automatic test_timeout();
        bit found = 0;
        uart_mode = 1; apply_reset();
        req_valid = 2'b11; req_data = 16'h6261;
        @(negedge clk); req_valid = 0;
        for (int k = 0; k < 10; k++) begin
            if (tx_start) begin found = 1; break; end
            @(negedge clk);
        end
        checks++; if (!found || tx_data !== 8'h61) begin
            errors++; $display("FAIL tmo_first got found=%b data=%h want 1/61", found, tx_data); end
        repeat (16) @(negedge clk);
        checks++; if (tx_active !== 1'b1) begin errors++; $display("FAIL tmo_still_waiting got %b want 1", tx_active); end
        @(negedge clk);
        checks++; if (tx_active !== 1'b0 || tx_start !== 1'b0) begin
            errors++; $display("FAIL tmo_idle got active=%b start=%b want 0/0", tx_active, tx_start); end
        @(negedge clk);
        checks++; if (tx_start !== 1'b1 || tx_data !== 8'h62 || grant_id !== 1'b1) begin
            errors++; $display("FAIL tmo_next got start=%b data=%h grant=%b want 1/62/1", tx_start, tx_data, grant_id); end
    endtask

    task automatic test_reset_mid();
        bit found = 0;
        int cnt;
        uart_mode = 0; apply_reset();
        req_valid = 2'b10; req_data = 16'h7100;
        @(negedge clk); req_valid = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (tx_busy) begin found = 1; break; end
        end
        checks++; if (!found) begin errors++; $display("FAIL mid_busy timeout got 0 want 1"); end
        req_valid = 2'b11; req_data = 16'h7372;
        @(negedge clk);
        req_valid = 2'b10;
        repeat (DEPTH_EXP) @(negedge clk);
        req_valid = 0;
        checks++; if (grant_id !== 1'b1 || tx_active !== 1'b1 || overflow[1] !== 1'b1) begin
            errors++; $display("FAIL mid_pre got grant=%b active=%b ovf=%b want 1/1/1x", grant_id, tx_active, overflow); end
        #2 rst = 1;
        #1;
        checks++; if (tx_start !== 1'b0 || tx_active !== 1'b0) begin
            errors++; $display("FAIL mid_rst_ctl got start=%b active=%b want 0/0", tx_start, tx_active); end
        checks++; if (grant_id !== 1'b0 || tx_data !== 8'h00) begin
            errors++; $display("FAIL mid_rst_data got grant=%b data=%h want 0/00", grant_id, tx_data); end
        checks++; if (req_ready !== 2'b11 || overflow !== 2'b00) begin
            errors++; $display("FAIL mid_rst_bufs got ready=%b ovf=%b want 11/00", req_ready, overflow); end
        @(negedge clk); @(negedge clk);
        rst = 0;
        cnt = sent.size();
        repeat (40) @(negedge clk);
        checks++; if (sent.size() != cnt || tx_active !== 1'b0) begin
            errors++; $display("FAIL mid_quiet got %0d starts active=%b want 0/0", sent.size() - cnt, tx_active); end
    endtask

    initial begin
        rst = 1; req_valid = 0; req_data = 0;
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_full();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
